mem_bus_arbiter: RTL and testbench

// - Shares the single 8-bit GB memory port between two requesters: the CPU (port 0) and the OAM/HDMA
//   DMA engine (port 1). Sits between cpu/dma and the memory top level.
// - Grants at most one transfer per clk and drives the registered memory address, write data and write strobe.
// - Routes read data back to the requester that issued the read, READ_LATENCY cycles after issue.
// - Includes a starvation guard so the CPU still makes progress under a continuous DMA stream.

---
 rtl/gb_mem_pkg.sv | 19 +
 rtl/arb_tag_pipe.sv | 32 +++
 rtl/mem_bus_arbiter.sv | 98 +++++++++
 tb/tb_mem_bus_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/gb_mem_pkg.sv
// Shared types and defaults for the GB memory-port arbiter slice.
package gb_mem_pkg;

  localparam int unsigned ADDR_W_DEF   = 16;
  localparam int unsigned DATA_W_DEF   = 8;
  localparam int unsigned READ_LAT_MIN = 1;
  localparam int unsigned READ_LAT_MAX = 4;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DMA = 1'b1
  } req_id_e;

  typedef struct packed {
    logic    valid;
    req_id_e owner;
  } rd_tag_t;

endpackage

// File: rtl/arb_tag_pipe.sv
// Read-tag shift register: tracks which requester owns each in-flight read.
module arb_tag_pipe
  import gb_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic    clk,
  input  logic    reset,
  input  rd_tag_t tag_in,
  output rd_tag_t head,
  output logic    any_valid
);

  rd_tag_t stage [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign head = stage[DEPTH-1];

  always_comb begin
    any_valid = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) any_valid = any_valid | stage[i].valid;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port (CPU / DMA) arbiter for the single GB memory port, with a CPU
// starvation guard and owner-tagged read return.
module mem_bus_arbiter
  import gb_mem_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned MAX_WAIT     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic              dma_we,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_write,
  output logic              mem_do_write,
  input  logic [DATA_W-1:0] mem_data_read,
  output logic              arb_busy
);

  if (READ_LATENCY < READ_LAT_MIN || READ_LATENCY > READ_LAT_MAX) begin : g_bad_latency
    $error("mem_bus_arbiter: READ_LATENCY must be in 1..4");
  end
  if (MAX_WAIT == 0 || MAX_WAIT > 255) begin : g_bad_max_wait
    $error("mem_bus_arbiter: MAX_WAIT must be in 1..255");
  end

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  logic [7:0]        wait_cnt;
  logic              any_gnt;
  logic [ADDR_W-1:0] g_addr;
  logic              g_we;
  logic [DATA_W-1:0] g_wdata;
  rd_tag_t           tag_in;
  rd_tag_t           tag_head;

  // DMA wins ties unless the CPU has been stalled for MAX_WAIT cycles.
  always_comb begin
    cpu_gnt = cpu_req & (~dma_req | (wait_cnt == WAIT_LIMIT));
    dma_gnt = dma_req & ~cpu_gnt;
    any_gnt = cpu_gnt | dma_gnt;
    g_addr  = dma_gnt ? dma_addr  : cpu_addr;
    g_we    = dma_gnt ? dma_we    : cpu_we;
    g_wdata = dma_gnt ? dma_wdata : cpu_wdata;
    tag_in.valid = any_gnt & ~g_we;
    tag_in.owner = dma_gnt ? REQ_DMA : REQ_CPU;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr       <= '0;
      mem_data_write <= '0;
      mem_do_write   <= 1'b0;
      wait_cnt       <= '0;
    end else begin
      if (any_gnt) begin
        mem_addr     <= g_addr;
        mem_do_write <= g_we;
        if (g_we) mem_data_write <= g_wdata;
      end else begin
        mem_do_write <= 1'b0;
      end

      if (!cpu_req || cpu_gnt) wait_cnt <= '0;
      else if (wait_cnt != WAIT_LIMIT) wait_cnt <= wait_cnt + 8'd1;
    end
  end

  arb_tag_pipe #(
    .DEPTH(READ_LATENCY)
  ) u_tag_pipe (
    .clk      (clk),
    .reset    (reset),
    .tag_in   (tag_in),
    .head     (tag_head),
    .any_valid(arb_busy)
  );

  assign cpu_rvalid = tag_head.valid & (tag_head.owner == REQ_CPU);
  assign dma_rvalid = tag_head.valid & (tag_head.owner == REQ_DMA);
  assign cpu_rdata  = mem_data_read;
  assign dma_rdata  = mem_data_read;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with READ_LATENCY = 3, MAX_WAIT = 8.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we, dma_gnt, dma_rvalid;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata, dma_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data_write, mem_data_read;
  logic        mem_do_write, arb_busy;

  int checks = 0;
  int errors = 0;
  int cpu_wins;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .ADDR_W(16),
    .DATA_W(8),
    .READ_LATENCY(3),
    .MAX_WAIT(8)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_we(dma_we), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_addr(mem_addr), .mem_data_write(mem_data_write), .mem_do_write(mem_do_write),
    .mem_data_read(mem_data_read), .arb_busy(arb_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    cpu_req = 0; cpu_addr = '0; cpu_we = 0; cpu_wdata = '0;
    dma_req = 0; dma_addr = '0; dma_we = 0; dma_wdata = '0;
    mem_data_read = '0;
    #1;
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_do_write", 32'(mem_do_write), 0);
    chk("rst_wdata", 32'(mem_data_write), 0);
    chk("rst_rvalid", {30'd0, cpu_rvalid, dma_rvalid}, 0);
    chk("rst_busy", 32'(arb_busy), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // CPU-only read 0x0150, returns 0xC3 three cycles after issue
    cpu_req = 1; cpu_addr = 16'h0150; cpu_we = 0;
    #1;
    chk("t1_cpu_gnt", {30'd0, cpu_gnt, dma_gnt}, 32'b10);
    tick();
    cpu_req = 0;
    chk("t1_mem_addr", 32'(mem_addr), 32'h0150);
    chk("t1_no_write", 32'(mem_do_write), 0);
    chk("t1_busy", 32'(arb_busy), 1);
    chk("t1_rv_early0", {30'd0, cpu_rvalid, dma_rvalid}, 0);
    tick();
    chk("t1_rv_early1", {30'd0, cpu_rvalid, dma_rvalid}, 0);
    tick();
    mem_data_read = 8'hC3;
    #1;
    chk("t1_rvalid", {30'd0, cpu_rvalid, dma_rvalid}, 32'b10);
    chk("t1_rdata", 32'(cpu_rdata), 32'hC3);
    tick();
    chk("t1_rv_after", {30'd0, cpu_rvalid, dma_rvalid}, 0);
    chk("t1_idle", 32'(arb_busy), 0);

    // Simultaneous reads: DMA first, CPU next, returns in issue order
    cpu_req = 1; cpu_addr = 16'h0100; cpu_we = 0;
    dma_req = 1; dma_addr = 16'hC000; dma_we = 0;
    #1;
    chk("t2_first_gnt", {30'd0, cpu_gnt, dma_gnt}, 32'b01);
    tick();
    dma_req = 0;
    chk("t2_addr_dma", 32'(mem_addr), 32'hC000);
    #1;
    chk("t2_second_gnt", {30'd0, cpu_gnt, dma_gnt}, 32'b10);
    tick();
    cpu_req = 0;
    chk("t2_addr_cpu", 32'(mem_addr), 32'h0100);
    tick();
    mem_data_read = 8'h77; #1;
    chk("t2_ret_dma", {30'd0, cpu_rvalid, dma_rvalid}, 32'b01);
    chk("t2_dma_rdata", 32'(dma_rdata), 32'h77);
    tick();
    mem_data_read = 8'h88; #1;
    chk("t2_ret_cpu", {30'd0, cpu_rvalid, dma_rvalid}, 32'b10);
    chk("t2_cpu_rdata", 32'(cpu_rdata), 32'h88);
    tick();
    chk("t2_ret_none", {30'd0, cpu_rvalid, dma_rvalid}, 0);

    // Continuous DMA writes, CPU waiting: CPU forced through at cycle 8
    cpu_req = 1; cpu_addr = 16'h2000; cpu_we = 1; cpu_wdata = 8'h11;
    dma_req = 1; dma_addr = 16'h3000; dma_we = 1; dma_wdata = 8'h22;
    cpu_wins = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk($sformatf("t3_gnt_c%0d", i), {30'd0, cpu_gnt, dma_gnt}, (i == 8) ? 32'b10 : 32'b01);
      if (cpu_gnt) cpu_wins++;
      tick();
      chk($sformatf("t3_addr_c%0d", i), 32'(mem_addr), (i == 8) ? 32'h2000 : 32'h3000);
      chk($sformatf("t3_wr_c%0d", i), {23'd0, mem_do_write, mem_data_write}, (i == 8) ? 32'h111 : 32'h122);
      if (i == 8) cpu_req = 0;
    end
    chk("t3_cpu_once", 32'(cpu_wins), 1);
    dma_req = 0;
    repeat (3) tick();
    chk("t3_drain", {29'd0, cpu_rvalid, dma_rvalid, arb_busy}, 0);

    // DMA write 0xFE00 <= 0x5A
    dma_req = 1; dma_addr = 16'hFE00; dma_we = 1; dma_wdata = 8'h5A;
    #1;
    chk("t4_gnt", {30'd0, cpu_gnt, dma_gnt}, 32'b01);
    tick();
    dma_req = 0;
    chk("t4_strobe", 32'(mem_do_write), 1);
    chk("t4_addr", 32'(mem_addr), 32'hFE00);
    chk("t4_wdata", 32'(mem_data_write), 32'h5A);
    chk("t4_busy", 32'(arb_busy), 0);
    tick();
    chk("t4_strobe_off", 32'(mem_do_write), 0);
    chk("t4_wdata_hold", 32'(mem_data_write), 32'h5A);
    repeat (2) tick();
    chk("t4_no_rvalid", {30'd0, cpu_rvalid, dma_rvalid}, 0);

    // Back-to-back CPU reads 0x0000..0x0003
    for (int c = 0; c < 8; c++) begin
      if (c < 4) begin
        cpu_req = 1; cpu_addr = 16'(c); cpu_we = 0;
        #1;
        chk($sformatf("t5_gnt_%0d", c), 32'(cpu_gnt), 1);
      end else begin
        cpu_req = 0;
      end
      tick();
      if (c < 4) chk($sformatf("t5_addr_%0d", c), 32'(mem_addr), 32'(c));
      mem_data_read = 8'(8'h10 + c);
      #1;
      chk($sformatf("t5_rv_%0d", c), {30'd0, cpu_rvalid, dma_rvalid}, (c >= 2 && c <= 5) ? 32'b10 : 32'b00);
      if (c >= 2 && c <= 5) chk($sformatf("t5_rdata_%0d", c), 32'(cpu_rdata), 32'(8'h10 + c));
      chk($sformatf("t5_busy_%0d", c), 32'(arb_busy), (c <= 5) ? 1 : 0);
    end

    // Reset one cycle after a granted read
    cpu_req = 1; cpu_addr = 16'h1234; cpu_we = 0;
    #1;
    chk("t6_gnt", 32'(cpu_gnt), 1);
    tick();
    cpu_req = 0;
    chk("t6_addr", 32'(mem_addr), 32'h1234);
    chk("t6_busy", 32'(arb_busy), 1);
    #3 reset = 1'b1;
    #1;
    chk("t6_async_addr", 32'(mem_addr), 0);
    chk("t6_async_wdata", 32'(mem_data_write), 0);
    chk("t6_async_busy", 32'(arb_busy), 0);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("t6_no_rv_%0d", c), {29'd0, cpu_rvalid, dma_rvalid, arb_busy}, 0);
    end
    cpu_req = 1; cpu_addr = 16'h0200; cpu_we = 0;
    dma_req = 1; dma_addr = 16'h0300; dma_we = 0;
    #1;
    chk("t6_post_gnt", {30'd0, cpu_gnt, dma_gnt}, 32'b01);
    tick();
    cpu_req = 0; dma_req = 0;
    chk("t6_post_addr", 32'(mem_addr), 32'h0300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
